// File: rtl/fetch_pkg.sv
// Shared types and length-field helpers for the instruction-fetch sequencer.
package fetch_pkg;

   typedef enum logic [2:0] {
      S_ADDR,
      S_WAIT,
      S_LATCH,
      S_HOLD,
      S_FAULT
   } state_t;

   // Width of the length field; a single-word ISA carries no field at all.
   function automatic int len_field_w(input int max_words);
      return (max_words > 1) ? $clog2(max_words) : 0;
   endfunction

   // The field occupies the top bits of word 0.
   function automatic int len_field_lsb(input int data_w, input int max_words);
      return data_w - len_field_w(max_words);
   endfunction

endpackage

// File: rtl/fetch_pc.sv
// Fetch program counter: synchronous reset, load over increment, wraps silently.
module fetch_pc #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk) begin
      if (rst)
         pc <= RESET_PC;
      else if (load)
         pc <= load_val;
      else if (inc)
         pc <= pc + ADDR_W'(1);
   end

endmodule

// File: rtl/fetch_seq.sv
// Variable-length instruction fetch over the MAR/MDR handshake, with branch
// redirect, memory timeout fault and a held instruction register.
//
//   state   | meaning
//   S_ADDR  | present pc to MAR
//   S_WAIT  | memory read in flight, waiting for mfc
//   S_LATCH | word captured, pc advances
//   S_HOLD  | instruction complete, held until done
//   S_FAULT | mfc timeout, held until branch or reset
module fetch_seq
   import fetch_pkg::*;
#(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 16,
   parameter int                MAX_WORDS = 4,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                TIMEOUT   = 15
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  mfc,
   input  logic [DATA_W-1:0]                     mem_data,
   input  logic                                  done,
   input  logic                                  branch_en,
   input  logic [ADDR_W-1:0]                     branch_addr,
   output logic [ADDR_W-1:0]                     mem_addr,
   output logic                                  mar_in,
   output logic                                  mem_en,
   output logic                                  mem_rw,
   output logic                                  mdr_out,
   output logic                                  ir_in,
   output logic [ADDR_W-1:0]                     pc_out,
   output logic [DATA_W*MAX_WORDS-1:0]           ir_out,
   output logic [len_field_w(MAX_WORDS):0]       ir_len,
   output logic                                  ir_valid,
   output logic                                  fetch_fault
);

   localparam int LW        = len_field_w(MAX_WORDS);
   localparam int FIELD_LSB = len_field_lsb(DATA_W, MAX_WORDS);
   localparam int LEN_W     = LW + 1;
   localparam int IDX_W     = (LW > 0) ? LW : 1;
   localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t                  state;
   state_t                  state_nxt;
   logic [IDX_W-1:0]        idx;
   logic [LEN_W-1:0]        len;
   logic [CNT_W-1:0]        cnt;
   logic [DATA_W-1:0]       ir_words [MAX_WORDS];
   logic [ADDR_W-1:0]       pc;
   logic                    last_word;
   logic                    timeout_hit;

   // Shifting by the full word width leaves zero, so MAX_WORDS=1 decodes to 1.
   function automatic logic [LEN_W-1:0] decode_len(input logic [DATA_W-1:0] w);
      return LEN_W'(w >> FIELD_LSB) + LEN_W'(1);
   endfunction

   assign last_word   = (LEN_W'(idx) == len - LEN_W'(1));
   assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

   fetch_pc #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .rst      (rst),
      .load     (branch_en),
      .load_val (branch_addr),
      .inc      (state == S_LATCH),
      .pc       (pc)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_ADDR;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (branch_en) begin
         state_nxt = S_ADDR;
      end else begin
         case (state)
            S_ADDR:  state_nxt = S_WAIT;
            S_WAIT: begin
               if (mfc)
                  state_nxt = S_LATCH;
               else if (timeout_hit)
                  state_nxt = S_FAULT;
            end
            S_LATCH: state_nxt = last_word ? S_HOLD : S_ADDR;
            S_HOLD:  if (done) state_nxt = S_ADDR;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_ADDR;
         endcase
      end
   end

   // Word slot and length are captured on the edge that accepts mfc.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= '0;
         len      <= LEN_W'(1);
         cnt      <= '0;
         ir_words <= '{default: '0};
      end else if (branch_en) begin
         idx <= '0;
      end else begin
         case (state)
            S_ADDR: cnt <= '0;
            S_WAIT: begin
               if (mfc) begin
                  ir_words[idx] <= mem_data;
                  if (idx == '0)
                     len <= decode_len(mem_data);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_LATCH: if (!last_word) idx <= idx + IDX_W'(1);
            S_HOLD: begin
               if (done) begin
                  idx      <= '0;
                  ir_words <= '{default: '0};
               end
            end
            default: ;
         endcase
      end
   end

   // The address strobe stays quiet while reset is held so reset looks idle.
   always_comb begin
      mar_in      = 1'b0;
      mem_en      = 1'b0;
      mdr_out     = 1'b0;
      ir_in       = 1'b0;
      ir_valid    = 1'b0;
      fetch_fault = 1'b0;
      case (state)
         S_ADDR:  mar_in      = !rst;
         S_WAIT:  mem_en      = 1'b1;
         S_LATCH: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
         S_HOLD:  ir_valid    = 1'b1;
         S_FAULT: fetch_fault = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      for (int i = 0; i < MAX_WORDS; i++)
         ir_out[i*DATA_W +: DATA_W] = ir_words[i];
   end

   assign mem_rw   = 1'b1;
   assign mem_addr = pc;
   assign pc_out   = pc;
   assign ir_len   = len;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed scenarios plus random traffic against a
// transaction-level model of the fetch rules.
module tb_fetch_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mfc = 1'b0;
   logic        done = 1'b0;
   logic        branch_en = 1'b0;
   logic [15:0] mem_data = '0;
   logic [15:0] branch_addr = '0;

   logic [15:0] mem_addr, pc_out;
   logic        mar_in, mem_en, mem_rw, mdr_out, ir_in, ir_valid, fetch_fault;
   logic [63:0] ir_out;
   logic [2:0]  ir_len;

   int checks = 0;
   int passes = 0;

   fetch_seq #(
      .DATA_W    (16),
      .ADDR_W    (16),
      .MAX_WORDS (4),
      .RESET_PC  (16'h0000),
      .TIMEOUT   (15)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mfc         (mfc),
      .mem_data    (mem_data),
      .done        (done),
      .branch_en   (branch_en),
      .branch_addr (branch_addr),
      .mem_addr    (mem_addr),
      .mar_in      (mar_in),
      .mem_en      (mem_en),
      .mem_rw      (mem_rw),
      .mdr_out     (mdr_out),
      .ir_in       (ir_in),
      .pc_out      (pc_out),
      .ir_out      (ir_out),
      .ir_len      (ir_len),
      .ir_valid    (ir_valid),
      .fetch_fault (fetch_fault)
   );

   always #5 clk = ~clk;

   // Model: what the sequencer is doing right now, in terms of the fetch story.
   localparam int A_PRESENT = 0;   // address on MAR
   localparam int A_AWAIT   = 1;   // read outstanding
   localparam int A_TAKE    = 2;   // word just taken
   localparam int A_HOLD    = 3;   // instruction handed to execute
   localparam int A_FAULT   = 4;   // memory never answered

   bit live = 0;
   int m_act, m_pc, m_got, m_len, m_waited;
   int m_words [4];

   always @(posedge clk) begin
      if (rst) begin
         live     = 1;
         m_act    = A_PRESENT;
         m_pc     = 0;
         m_got    = 0;
         m_len    = 1;
         m_waited = 0;
         foreach (m_words[i]) m_words[i] = 0;
      end else if (live) begin
         if (branch_en) begin
            m_pc  = int'(branch_addr);
            m_got = 0;
            m_act = A_PRESENT;
         end else if (m_act == A_PRESENT) begin
            m_act    = A_AWAIT;
            m_waited = 0;
         end else if (m_act == A_AWAIT) begin
            if (mfc) begin
               m_words[m_got] = int'(mem_data);
               if (m_got == 0) m_len = int'(mem_data[15:14]) + 1;
               m_act = A_TAKE;
            end else begin
               m_waited++;
               if (m_waited == 15) m_act = A_FAULT;
            end
         end else if (m_act == A_TAKE) begin
            m_pc = (m_pc + 1) % 65536;
            if (m_got + 1 >= m_len) m_act = A_HOLD;
            else begin
               m_got++;
               m_act = A_PRESENT;
            end
         end else if (m_act == A_HOLD) begin
            if (done) begin
               m_got = 0;
               foreach (m_words[i]) m_words[i] = 0;
               m_act = A_PRESENT;
            end
         end
      end
   end

   function automatic logic [63:0] model_ir();
      logic [63:0] v;
      for (int i = 0; i < 4; i++) v[16*i +: 16] = 16'(m_words[i]);
      return v;
   endfunction

   logic [105:0] exp_v, act_v;
   always @(negedge clk) begin
      if (live) begin
         exp_v = {16'(m_pc), (m_act == A_PRESENT) && !rst, m_act == A_AWAIT, 1'b1,
                  m_act == A_TAKE, m_act == A_TAKE, 16'(m_pc), model_ir(), 3'(m_len),
                  m_act == A_HOLD, m_act == A_FAULT};
         act_v = {mem_addr, mar_in, mem_en, mem_rw, mdr_out, ir_in, pc_out, ir_out, ir_len,
                  ir_valid, fetch_fault};
         checks++;
         if (act_v === exp_v) passes++;
         else $display("FAIL cycle_compare t=%0t dut=%h model=%h", $time, act_v, exp_v);
      end
   end

   int irin_cnt = 0;
   int memen_cnt = 0;
   always @(negedge clk) begin
      if (ir_in === 1'b1) irin_cnt++;
      if (mem_en === 1'b1) memen_cnt++;
   end

   task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called while the sequencer presents an address; returns one tick after the latch cycle.
   task automatic fetch_word(input logic [15:0] data, input int waits);
      tick();
      mfc = 1'b0;
      repeat (waits) tick();
      mfc = 1'b1;
      mem_data = data;
      tick();
      mfc = 1'b0;
      tick();
   endtask

   task automatic chk_reset(input string name);
      lit({name, "_strobes"}, {mar_in, mem_en, mdr_out, ir_in, ir_valid, fetch_fault, mem_rw}, 7'b0000001);
      lit({name, "_pc"}, pc_out, 16'h0000);
      lit({name, "_ir"}, ir_out, 64'h0);
      lit({name, "_len"}, ir_len, 3'd1);
   endtask

   int base;
   int pms [4] = '{0, 25, 50, 90};

   initial begin
      tick();
      tick();
      chk_reset("reset");
      rst = 1'b0;
      #1;
      lit("addr_after_reset", {mar_in, mem_addr}, {1'b1, 16'h0000});

      fetch_word(16'h0123, 0);
      lit("w1_valid", ir_valid, 1'b1);
      lit("w1_ir", ir_out[15:0], 16'h0123);
      lit("w1_len", ir_len, 3'd1);
      lit("w1_pc", pc_out, 16'h0001);
      done = 1'b1;
      tick();
      done = 1'b0;
      lit("done_restart", {mar_in, mem_addr, ir_valid}, {1'b1, 16'h0001, 1'b0});

      branch_en = 1'b1;
      branch_addr = 16'h0000;
      tick();
      branch_en = 1'b0;
      base = irin_cnt;
      fetch_word(16'h8AAA, 0);
      fetch_word(16'h1111, 0);
      fetch_word(16'h2222, 0);
      lit("w3_valid", ir_valid, 1'b1);
      lit("w3_len", ir_len, 3'd3);
      lit("w3_ir", ir_out[47:0], 48'h2222_1111_8AAA);
      lit("w3_pc", pc_out, 16'h0003);
      lit("w3_ir_in_pulses", irin_cnt - base, 3);

      done = 1'b1;
      tick();
      done = 1'b0;
      base = memen_cnt;
      fetch_word(16'h0055, 5);
      lit("wait_mem_en_cycles", memen_cnt - base, 6);
      lit("wait_valid_nofault", {ir_valid, fetch_fault}, 2'b10);
      lit("wait_ir", ir_out[15:0], 16'h0055);

      done = 1'b1;
      tick();
      done = 1'b0;
      base = memen_cnt;
      tick();
      repeat (14) tick();
      lit("timeout_edge_minus1", {fetch_fault, mem_en}, 2'b01);
      tick();
      lit("timeout_fault", {fetch_fault, mem_en}, 2'b10);
      lit("timeout_wait_cycles", memen_cnt - base, 15);
      branch_en = 1'b1;
      branch_addr = 16'h0040;
      tick();
      branch_en = 1'b0;
      lit("fault_recover", {fetch_fault, mar_in, mem_addr}, {1'b0, 1'b1, 16'h0040});

      fetch_word(16'h4321, 0);
      tick();
      branch_en = 1'b1;
      branch_addr = 16'h0100;
      tick();
      branch_en = 1'b0;
      mfc = 1'b1;
      mem_data = 16'hBEEF;
      tick();
      mfc = 1'b0;
      lit("abort_pc", {pc_out, mem_addr}, {16'h0100, 16'h0100});
      lit("abort_no_valid", ir_valid, 1'b0);
      lit("abort_ir_kept", ir_out[31:0], 32'h0000_4321);
      mfc = 1'b1;
      mem_data = 16'h0007;
      tick();
      mfc = 1'b0;
      tick();
      lit("abort_refetch", {ir_valid, ir_out[15:0], pc_out}, {1'b1, 16'h0007, 16'h0101});
      branch_en = 1'b1;
      done = 1'b1;
      branch_addr = 16'h0200;
      tick();
      branch_en = 1'b0;
      done = 1'b0;
      lit("branch_beats_done", {mar_in, mem_addr, ir_valid}, {1'b1, 16'h0200, 1'b0});
      lit("branch_keeps_ir", ir_out[15:0], 16'h0007);

      branch_en = 1'b1;
      branch_addr = 16'hFFFF;
      tick();
      branch_en = 1'b0;
      lit("wrap_first_addr", mem_addr, 16'hFFFF);
      fetch_word(16'h4AAA, 0);
      lit("wrap_second_addr", {mar_in, mem_addr}, {1'b1, 16'h0000});
      fetch_word(16'h5555, 0);
      lit("wrap_pc", pc_out, 16'h0001);
      lit("wrap_len", ir_len, 3'd2);
      lit("wrap_ir", ir_out[31:0], 32'h5555_4AAA);

      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      mfc = 1'b1;
      mem_data = 16'h9999;
      tick();
      mfc = 1'b0;
      lit("latch_before_rst", ir_in, 1'b1);
      rst = 1'b1;
      tick();
      chk_reset("rst_in_latch");
      rst = 1'b0;

      for (int seg = 0; seg < 15; seg++) begin
         int pm;
         pm = pms[$urandom_range(0, 3)];
         for (int c = 0; c < 200; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            branch_en = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) branch_addr = 16'hFFFF - 16'($urandom_range(0, 2));
            else branch_addr = 16'($urandom);
            done = ($urandom_range(0, 3) == 0);
            mfc = ($urandom_range(0, 99) < pm);
            mem_data = 16'($urandom);
            tick();
         end
      end

      rst = 1'b0;
      branch_en = 1'b0;
      done = 1'b0;
      mfc = 1'b0;
      repeat (3) tick();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
